// File: rtl/quiz_pkg.sv
// Shared state encoding, winner codes and a saturating score helper for the
// quiz round controller.
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_PLAY   = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Scores stick at 15 rather than wrapping back to zero.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// A clear restarts the count so the first tick lands TICK_DIV cycles later.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] count_q;

  assign tick_o = (count_q == PW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1, wrapping on the tick, restarting on clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/quiz_round_controller.sv
// Sequences two-player quiz rounds: arms the RNG and holds quiz_reset, runs the
// countdown, arbitrates the first correct answer, keeps score and ends the game.
module quiz_round_controller
  import quiz_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned ROUND_TIME   = 10,
  parameter int unsigned RESULT_TICKS = 3,
  parameter int unsigned ROUNDS       = 9,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned CLR_CYCLES   = 8,
  parameter int unsigned GUARD        = 4
) (
  input  logic       basys3_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       correct_p1,
  input  logic       correct_p2,
  output logic       quiz_reset,
  output logic       rng_trigger,
  output logic [3:0] time_left,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] round_cnt,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic       game_over
);

  // One shared cycle/tick counter serves ARM length, PLAY guard and RESULT hold.
  localparam int unsigned CMAX01 = (CLR_CYCLES > GUARD) ? CLR_CYCLES : GUARD;
  localparam int unsigned CMAX   = (CMAX01 > RESULT_TICKS) ? CMAX01 : RESULT_TICKS;
  localparam int unsigned CW     = $clog2(CMAX + 1);

  state_e        state_q, state_d;
  logic [3:0]    score_p1_q, score_p1_d;
  logic [3:0]    score_p2_q, score_p2_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    time_q, time_d;
  logic [1:0]    winner_q, winner_d;
  logic          rng_q, rng_d;
  logic          tie_q, tie_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic p1_meta_q, p1_sync_q;
  logic p2_meta_q, p2_sync_q;
  logic start_meta_q, start_sync_q, start_prev_q;

  logic start_edge;
  logic guard_open;
  logic any_ok;
  logic pre_clr;
  logic tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (basys3_clk),
    .rst_ni (rst_n),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );

  assign start_edge = start_sync_q & ~start_prev_q;
  assign guard_open = (cnt_q >= CW'(GUARD));
  assign any_ok     = guard_open & (p1_sync_q | p2_sync_q);

  // Bring the 25 MHz flags and the start level into this domain, keep start history.
  always_ff @(posedge basys3_clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_meta_q    <= 1'b0;
      p1_sync_q    <= 1'b0;
      p2_meta_q    <= 1'b0;
      p2_sync_q    <= 1'b0;
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      p1_meta_q    <= correct_p1;
      p1_sync_q    <= p1_meta_q;
      p2_meta_q    <= correct_p2;
      p2_sync_q    <= p2_meta_q;
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  // Game state registers; tie priority survives abort and is cleared only by rst_n.
  always_ff @(posedge basys3_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score_p1_q <= '0;
      score_p2_q <= '0;
      round_q    <= '0;
      time_q     <= '0;
      winner_q   <= WIN_NONE;
      rng_q      <= 1'b0;
      tie_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      round_q    <= round_d;
      time_q     <= time_d;
      winner_q   <= winner_d;
      rng_q      <= rng_d;
      tie_q      <= tie_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: abort overrides everything, otherwise walk the round sequence.
  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    round_d    = round_q;
    time_d     = time_q;
    winner_d   = winner_q;
    rng_d      = rng_q;
    tie_d      = tie_q;
    cnt_d      = cnt_q;
    pre_clr    = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      score_p1_d = '0;
      score_p2_d = '0;
      round_d    = '0;
      time_d     = '0;
      winner_d   = WIN_NONE;
      rng_d      = 1'b0;
      cnt_d      = '0;
      pre_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state_d    = ST_ARM;
            score_p1_d = '0;
            score_p2_d = '0;
            round_d    = 4'd1;
            winner_d   = WIN_NONE;
            rng_d      = ~rng_q;
            cnt_d      = '0;
          end
        end

        ST_ARM: begin
          if (cnt_q == CW'(CLR_CYCLES - 1)) begin
            state_d = ST_PLAY;
            time_d  = 4'(ROUND_TIME);
            cnt_d   = '0;
            pre_clr = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_PLAY: begin
          if (!guard_open) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (any_ok) begin
            state_d = ST_RESULT;
            cnt_d   = '0;
            pre_clr = 1'b1;
            if (p1_sync_q && p2_sync_q) begin
              winner_d = tie_q ? WIN_P2 : WIN_P1;
              tie_d    = ~tie_q;
              if (tie_q) begin
                score_p2_d = sat_inc4(score_p2_q);
              end else begin
                score_p1_d = sat_inc4(score_p1_q);
              end
            end else if (p1_sync_q) begin
              winner_d   = WIN_P1;
              score_p1_d = sat_inc4(score_p1_q);
            end else begin
              winner_d   = WIN_P2;
              score_p2_d = sat_inc4(score_p2_q);
            end
          end else if (tick) begin
            if (time_q == 4'd1) begin
              state_d  = ST_RESULT;
              time_d   = 4'd0;
              winner_d = WIN_NONE;
              cnt_d    = '0;
              pre_clr  = 1'b1;
            end else begin
              time_d = time_q - 4'd1;
            end
          end
        end

        ST_RESULT: begin
          if (tick) begin
            if (cnt_q == CW'(RESULT_TICKS - 1)) begin
              cnt_d = '0;
              if ((score_p1_q == 4'(WIN_SCORE)) || (score_p2_q == 4'(WIN_SCORE)) ||
                  (round_q == 4'(ROUNDS))) begin
                state_d = ST_DONE;
                if (score_p1_q > score_p2_q) begin
                  winner_d = WIN_P1;
                end else if (score_p2_q > score_p1_q) begin
                  winner_d = WIN_P2;
                end else begin
                  winner_d = WIN_DRAW;
                end
              end else begin
                state_d = ST_ARM;
                round_d = round_q + 4'd1;
                rng_d   = ~rng_q;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign quiz_reset  = (state_q != ST_PLAY);
  assign game_over   = (state_q == ST_DONE);
  assign state       = state_q;
  assign rng_trigger = rng_q;
  assign time_left   = time_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign round_cnt   = round_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller with short ticks so whole games fit
// in a few hundred cycles. Inputs change and outputs are sampled on negedges.
module tb_quiz_round_controller;

  logic       basys3_clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       correct_p1;
  logic       correct_p2;
  logic       quiz_reset;
  logic       rng_trigger;
  logic [3:0] time_left;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [3:0] round_cnt;
  logic [1:0] winner;
  logic [2:0] state;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  quiz_round_controller #(
    .TICK_DIV     (10),
    .ROUND_TIME   (3),
    .RESULT_TICKS (1),
    .ROUNDS       (3),
    .WIN_SCORE    (2),
    .CLR_CYCLES   (8),
    .GUARD        (4)
  ) dut (
    .basys3_clk  (basys3_clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .correct_p1  (correct_p1),
    .correct_p2  (correct_p2),
    .quiz_reset  (quiz_reset),
    .rng_trigger (rng_trigger),
    .time_left   (time_left),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .round_cnt   (round_cnt),
    .winner      (winner),
    .state       (state),
    .game_over   (game_over)
  );

  initial basys3_clk = 1'b0;
  always #5 basys3_clk = ~basys3_clk;

  task automatic applyStimulus(input logic st, input logic ab, input logic c1, input logic c2);
    start      = st;
    abort      = ab;
    correct_p1 = c1;
    correct_p2 = c2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge basys3_clk);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    #2;
    checkOutput("rst_state",      32'(state),       0);
    checkOutput("rst_quiz_reset", 32'(quiz_reset),  1);
    checkOutput("rst_rng",        32'(rng_trigger), 0);
    checkOutput("rst_round",      32'(round_cnt),   0);
    checkOutput("rst_game_over",  32'(game_over),   0);
    step(2);
    rst_n = 1'b1;
    step(3);
    checkOutput("idle_state",  32'(state),      0);
    checkOutput("idle_qreset", 32'(quiz_reset), 1);
    checkOutput("idle_time",   32'(time_left),  0);
    checkOutput("idle_score1", 32'(score_p1),   0);
    checkOutput("idle_winner", 32'(winner),     0);

    // Game 1: P1 answers late in round 1, then a tie goes to P1 and ends the game.
    $display("[TB] game 1");
    applyStimulus(1, 0, 0, 0);
    step(2);
    checkOutput("g1_pre_arm", 32'(state), 0);
    step(1);
    checkOutput("g1_arm_state", 32'(state),       1);
    checkOutput("g1_arm_rng",   32'(rng_trigger), 1);
    checkOutput("g1_arm_round", 32'(round_cnt),   1);
    applyStimulus(0, 0, 0, 0);
    step(7);
    checkOutput("g1_arm_last", 32'(state), 1);
    step(1);
    checkOutput("g1_play_state",  32'(state),      2);
    checkOutput("g1_play_time",   32'(time_left),  3);
    checkOutput("g1_play_qreset", 32'(quiz_reset), 0);
    step(20);
    checkOutput("g1_time_at20", 32'(time_left), 1);
    applyStimulus(0, 0, 1, 0);
    step(2);
    checkOutput("g1_still_play", 32'(state), 2);
    step(1);
    checkOutput("g1_res_state",  32'(state),     3);
    checkOutput("g1_res_winner", 32'(winner),    1);
    checkOutput("g1_res_score1", 32'(score_p1),  1);
    checkOutput("g1_res_score2", 32'(score_p2),  0);
    checkOutput("g1_res_time",   32'(time_left), 1);
    applyStimulus(0, 0, 0, 0);
    step(9);
    checkOutput("g1_res_hold", 32'(state), 3);
    step(1);
    checkOutput("g1_r2_arm",   32'(state),       1);
    checkOutput("g1_r2_round", 32'(round_cnt),   2);
    checkOutput("g1_r2_rng",   32'(rng_trigger), 0);
    step(8);
    checkOutput("g1_r2_play", 32'(state), 2);
    step(5);
    applyStimulus(0, 0, 1, 1);
    step(3);
    checkOutput("g1_tie_state",  32'(state),    3);
    checkOutput("g1_tie_winner", 32'(winner),   1);
    checkOutput("g1_tie_score1", 32'(score_p1), 2);
    applyStimulus(0, 0, 0, 0);
    step(10);
    checkOutput("g1_done_state",  32'(state),     4);
    checkOutput("g1_done_over",   32'(game_over), 1);
    checkOutput("g1_done_winner", 32'(winner),    1);
    checkOutput("g1_done_round",  32'(round_cnt), 2);

    // Game 2: restart from DONE, tie now goes to P2, then abort mid-PLAY.
    $display("[TB] game 2");
    applyStimulus(1, 0, 0, 0);
    step(3);
    checkOutput("g2_arm_state",  32'(state),       1);
    checkOutput("g2_arm_round",  32'(round_cnt),   1);
    checkOutput("g2_arm_score1", 32'(score_p1),    0);
    checkOutput("g2_arm_rng",    32'(rng_trigger), 1);
    checkOutput("g2_arm_over",   32'(game_over),   0);
    applyStimulus(0, 0, 0, 0);
    step(8);
    step(5);
    applyStimulus(0, 0, 1, 1);
    step(3);
    checkOutput("g2_tie_winner", 32'(winner),   2);
    checkOutput("g2_tie_score2", 32'(score_p2), 1);
    checkOutput("g2_tie_score1", 32'(score_p1), 0);
    applyStimulus(0, 0, 0, 0);
    step(10);
    checkOutput("g2_r2_arm", 32'(state),       1);
    checkOutput("g2_r2_rng", 32'(rng_trigger), 0);
    step(8);
    step(10);
    checkOutput("g2_r2_time", 32'(time_left), 2);
    applyStimulus(0, 1, 0, 0);
    step(1);
    checkOutput("g2_abort_state",  32'(state),       0);
    checkOutput("g2_abort_score2", 32'(score_p2),    0);
    checkOutput("g2_abort_round",  32'(round_cnt),   0);
    checkOutput("g2_abort_winner", 32'(winner),      0);
    checkOutput("g2_abort_time",   32'(time_left),   0);
    checkOutput("g2_abort_qreset", 32'(quiz_reset),  1);
    applyStimulus(0, 0, 0, 0);
    step(3);

    // Game 3: nobody answers; three timeouts end in a draw.
    $display("[TB] game 3");
    applyStimulus(1, 0, 0, 0);
    step(3);
    checkOutput("g3_arm_rng", 32'(rng_trigger), 1);
    applyStimulus(0, 0, 0, 0);
    step(8);
    checkOutput("g3_time3", 32'(time_left), 3);
    step(10);
    checkOutput("g3_time2", 32'(time_left), 2);
    step(10);
    checkOutput("g3_time1", 32'(time_left), 1);
    step(9);
    checkOutput("g3_last_play", 32'(state), 2);
    step(1);
    checkOutput("g3_to_state",  32'(state),     3);
    checkOutput("g3_to_time",   32'(time_left), 0);
    checkOutput("g3_to_winner", 32'(winner),    0);
    checkOutput("g3_to_score1", 32'(score_p1),  0);
    checkOutput("g3_to_score2", 32'(score_p2),  0);
    step(10);
    checkOutput("g3_r2_round", 32'(round_cnt), 2);
    step(8);
    step(30);
    step(10);
    checkOutput("g3_r3_round", 32'(round_cnt),   3);
    checkOutput("g3_r3_rng",   32'(rng_trigger), 1);
    step(8);
    step(30);
    checkOutput("g3_r3_result", 32'(state), 3);
    step(10);
    checkOutput("g3_done_state",  32'(state),     4);
    checkOutput("g3_done_over",   32'(game_over), 1);
    checkOutput("g3_done_winner", 32'(winner),    3);

    // Game 4: an early P2 flag is masked by the guard; P2 then wins twice.
    $display("[TB] game 4");
    applyStimulus(1, 0, 0, 0);
    step(3);
    checkOutput("g4_arm_rng", 32'(rng_trigger), 0);
    applyStimulus(0, 0, 0, 1);
    step(8);
    checkOutput("g4_play_state", 32'(state), 2);
    step(2);
    applyStimulus(0, 0, 0, 0);
    step(4);
    checkOutput("g4_guard_ignore", 32'(state), 2);
    step(4);
    applyStimulus(0, 0, 0, 1);
    step(3);
    checkOutput("g4_res_state",  32'(state),     3);
    checkOutput("g4_res_winner", 32'(winner),    2);
    checkOutput("g4_res_score2", 32'(score_p2),  1);
    checkOutput("g4_res_time",   32'(time_left), 2);
    applyStimulus(0, 0, 0, 0);
    step(10);
    checkOutput("g4_r2_rng", 32'(rng_trigger), 1);
    step(8);
    step(5);
    applyStimulus(0, 0, 0, 1);
    step(3);
    checkOutput("g4_r2_score2", 32'(score_p2), 2);
    applyStimulus(0, 0, 0, 0);
    step(10);
    checkOutput("g4_done_state",  32'(state),     4);
    checkOutput("g4_done_winner", 32'(winner),    2);
    checkOutput("g4_done_round",  32'(round_cnt), 2);

    // Game 5: asynchronous reset in the middle of RESULT.
    $display("[TB] game 5");
    applyStimulus(1, 0, 0, 0);
    step(3);
    applyStimulus(0, 0, 0, 0);
    step(8);
    step(5);
    applyStimulus(0, 0, 1, 0);
    step(3);
    checkOutput("g5_res_score1", 32'(score_p1), 1);
    applyStimulus(0, 0, 0, 0);
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("g5_arst_state",  32'(state),       0);
    checkOutput("g5_arst_score1", 32'(score_p1),    0);
    checkOutput("g5_arst_round",  32'(round_cnt),   0);
    checkOutput("g5_arst_qreset", 32'(quiz_reset),  1);
    checkOutput("g5_arst_rng",    32'(rng_trigger), 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    checkOutput("g5_post_state", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quiz_round_controller.md
Name: quiz_round_controller

Overview:
- Sequences two-player quiz rounds around the quiz_mode datapath.
- Each round: re-arm the RNG, clear the sticky correct flags through quiz_reset, run a countdown, then arbitrate the first correct answer between P1 and P2.
- Keeps scores and rounds, and declares the game over.
- Sits beside quiz_mode in the top level, on basys3_clk.

Parameters:
- TICK_DIV, 100_000_000: basys3_clk cycles per timer tick (1 s).
- ROUND_TIME, 10: ticks allowed per round.
- RESULT_TICKS, 3: ticks the round result is held.
- ROUNDS, 9: maximum rounds per game.
- WIN_SCORE, 5: score that ends the game early.
- CLR_CYCLES, 8: cycles quiz_reset is held in ARM. Must be ≥4 so the 25 MHz domain samples it.
- GUARD, 4: cycles at PLAY start during which correct inputs are ignored.

Ports:
- basys3_clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; a rising edge starts a game
- abort  in  1  level; synchronous return to IDLE
- correct_p1  in  1  sticky flag from quiz_mode (25 MHz domain)
- correct_p2  in  1  sticky flag from quiz_mode (25 MHz domain)
- quiz_reset  out  1  clears quiz_mode correct flags
- rng_trigger  out  1  toggles once per round; the RNG reacts to any change
- time_left  out  4  ticks remaining in the round
- score_p1  out  4  P1 score
- score_p2  out  4  P2 score
- round_cnt  out  4  current round, 1-based
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw
- state  out  3  IDLE=0, ARM=1, PLAY=2, RESULT=3, DONE=4
- game_over  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; quiz_reset=1; all other outputs 0.
  - Prescaler, tie-priority register (tie_pri=P1) and synchronizers cleared.
- Input conditioning:
  - correct_p1 and correct_p2 pass through 2-flop synchronizers.
  - start is synchronized (2-flop) and edge-detected.
- Priority: abort > all. abort=1 in any state → IDLE next cycle, with reset values except rst-only state (tie_pri keeps its value).
- quiz_reset is 1 in every state except PLAY.
- IDLE:
  - start edge → ARM.
  - Same cycle: scores=0, round_cnt=0, winner=0.
- ARM:
  - On entry: rng_trigger toggles and round_cnt increments.
  - Stays exactly CLR_CYCLES cycles → PLAY.
  - On the PLAY transition: time_left=ROUND_TIME, prescaler=0, guard counter=0.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1; at wrap, time_left decrements.
  - Synced correct inputs are ignored while guard counter < GUARD.
  - Afterwards, first cycle with any synced correct → RESULT.
    - Only P1 → winner=1.
    - Only P2 → winner=2.
    - Both in the same cycle → winner=tie_pri, then tie_pri flips (round-robin).
  - Timeout: tick while time_left==1 → time_left=0, winner=0, RESULT.
  - Correct and timeout in the same cycle → the correct answer wins; time_left not decremented.
- RESULT:
  - On entry, the winner's score increments, saturating at 15.
  - Hold RESULT_TICKS ticks (prescaler restarted on entry).
  - Then, if either score == WIN_SCORE or round_cnt == ROUNDS → DONE, else → ARM.
- DONE:
  - game_over=1.
  - winner = higher scorer (1/2), or 3 if equal.
  - start edge → ARM with scores=0 and round_cnt=0.
- start edges outside IDLE and DONE are ignored.
- Widths:
  - time_left is 4-bit; ROUND_TIME ≤ 15.
  - Prescaler is $clog2(TICK_DIV) bits.
  - round_cnt does not wrap because ROUNDS ≤ 15.

Decomposition:
- Package quiz_pkg:
  - State encoding constants.
  - Winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW.
- One sub-module: tick_prescaler (counter with clear, emits a one-cycle tick). It is instantiated once and cleared on entry to PLAY and RESULT.

Test Plan (TICK_DIV=10, ROUND_TIME=3, RESULT_TICKS=1, CLR_CYCLES=8, GUARD=4, ROUNDS=3, WIN_SCORE=2):
- Reset release, no start → state=0, quiz_reset=1, all counters 0; start pulse → ARM 2 cycles after the edge, rng_trigger toggles, round_cnt=1, PLAY 8 cycles later.
- correct_p1 asserted 20 cycles into PLAY → winner=1, score_p1=1 about 3 cycles later; RESULT lasts 10 cycles, then ARM with round_cnt=2.
- correct_p1 and correct_p2 rise in the same cycle in two successive rounds → first round winner=1, second winner=2 (tie_pri alternates).
- No correct input → time_left 3,2,1,0 at 10-cycle spacing, winner=0, scores unchanged; after 3 rounds → DONE, game_over=1, winner=3.
- correct_p2 asserted during ARM and first 3 PLAY cycles only (quiz_reset held) → ignored; P2 wins twice → DONE after round 2, winner=2.
- abort mid-PLAY, then rst_n low mid-RESULT → IDLE next cycle, scores=0; async reset zeroes outputs immediately without a clock edge.
